dut_bus_master: RTL and testbench

Initiator for the DUT's ready/enable register interface: 3-bit address, 1-bit data, separate write and read channels. Accepts one command at a time on a valid/ready command port. Drives write_en/read_en only while the matching *_rdy is high, and captures read_data. Returns one response per command, including a timeout error if the DUT never becomes ready. Sits between a testbench/sequencer (or on-chip controller) and the DUT's write/read ports.

---
 rtl/dut_bus_master_pkg.sv | 26 ++
 rtl/dut_bus_master_if.sv | 49 ++++
 rtl/dut_bus_master_sat_counter.sv | 25 ++
 rtl/dut_bus_master.sv | 119 +++++++++++
 tb/tb_dut_bus_master.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dut_bus_master_pkg.sv
// Shared types for the DUT register-interface bus master.
// Holds bus widths, the FSM state encoding and the command/response records.
package dut_if_pkg;

   localparam int DUT_ADDR_W = 3;
   localparam int DUT_DATA_W = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_e;

   typedef struct packed {
      logic                  write;
      logic [DUT_ADDR_W-1:0] addr;
      logic [DUT_DATA_W-1:0] wdata;
   } cmd_t;

   typedef struct packed {
      logic                  is_write;
      logic [DUT_DATA_W-1:0] rdata;
      logic                  error;
   } rsp_t;

endpackage

// File: rtl/dut_bus_master_if.sv
// Command/response ports plus the DUT write/read channels of the bus master.
// The master modport is the bus master's view; slave is the sequencer/DUT side.
interface dut_bus_master_if;
   import dut_if_pkg::*;

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [DUT_ADDR_W-1:0] cmd_addr;
   logic [DUT_DATA_W-1:0] cmd_wdata;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DUT_DATA_W-1:0] rsp_rdata;
   logic                  rsp_is_write;
   logic                  rsp_error;

   logic [DUT_ADDR_W-1:0] write_address;
   logic [DUT_DATA_W-1:0] write_data;
   logic                  write_en;
   logic                  write_rdy;
   logic [DUT_ADDR_W-1:0] read_address;
   logic                  read_en;
   logic [DUT_DATA_W-1:0] read_data;
   logic                  read_rdy;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      output cmd_ready,
      output rsp_valid, rsp_rdata, rsp_is_write, rsp_error,
      input  rsp_ready,
      output write_address, write_data, write_en,
      input  write_rdy,
      output read_address, read_en,
      input  read_data, read_rdy
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      input  cmd_ready,
      input  rsp_valid, rsp_rdata, rsp_is_write, rsp_error,
      output rsp_ready,
      input  write_address, write_data, write_en,
      output write_rdy,
      input  read_address, read_en,
      output read_data, read_rdy
   );

endinterface

// File: rtl/dut_bus_master_sat_counter.sv
// Saturating up-counter used for the bus master statistics.
// Holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [WIDTH-1:0] value
);

   logic [WIDTH-1:0] value_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value_q <= '0;
      end else if (inc && (value_q != '1)) begin
         value_q <= value_q + 1'b1;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/dut_bus_master.sv
// Single-outstanding initiator for the DUT ready/enable register interface,
// with per-command timeout and saturating transfer/timeout statistics.
module dut_bus_master
   import dut_if_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TMR_W          = 8,
   parameter int CNT_W          = 16
) (
   input  logic              clk,
   input  logic              reset,
   dut_bus_master_if.master  bus,
   output logic              busy,
   output logic [CNT_W-1:0]  wr_done_count,
   output logic [CNT_W-1:0]  rd_done_count,
   output logic [CNT_W-1:0]  timeout_count
);

   state_e           state_q, state_d;
   cmd_t             cmd_q, cmd_d;
   rsp_t             rsp_q, rsp_d;
   logic [TMR_W-1:0] timer_q, timer_d;

   logic cmd_ready_w;
   logic accept;
   logic xfer;
   logic timed_out;

   assign accept    = bus.cmd_valid && cmd_ready_w;
   assign xfer      = (state_q == ISSUE) && (cmd_q.write ? bus.write_rdy : bus.read_rdy);
   // A ready channel in the limit cycle still transfers; only a silent DUT times out.
   assign timed_out = (state_q == ISSUE) && !xfer && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cmd_q   <= '0;
         rsp_q   <= '0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         rsp_q   <= rsp_d;
         timer_q <= timer_d;
      end
   end

   // NOTE: every comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      rsp_d   = rsp_q;
      timer_d = timer_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               cmd_d   = '{write: bus.cmd_write, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
               timer_d = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (xfer) begin
               rsp_d   = '{is_write: cmd_q.write,
                           rdata:    (cmd_q.write ? '0 : bus.read_data),
                           error:    1'b0};
               state_d = RESP;
            end else if (timed_out) begin
               rsp_d   = '{is_write: cmd_q.write, rdata: '0, error: 1'b1};
               state_d = RESP;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         RESP: begin
            if (bus.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready_w  = (state_q == IDLE) && !reset;
      bus.write_en = (state_q == ISSUE) && cmd_q.write && bus.write_rdy;
      bus.read_en  = (state_q == ISSUE) && !cmd_q.write && bus.read_rdy;
      bus.rsp_valid = (state_q == RESP);
      busy          = (state_q != IDLE);
   end

   assign bus.cmd_ready     = cmd_ready_w;
   assign bus.rsp_rdata     = rsp_q.rdata;
   assign bus.rsp_is_write  = rsp_q.is_write;
   assign bus.rsp_error     = rsp_q.error;
   assign bus.write_address = cmd_q.addr;
   assign bus.read_address  = cmd_q.addr;
   assign bus.write_data    = cmd_q.wdata;

   sat_counter #(.WIDTH(CNT_W)) u_wr_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (xfer && cmd_q.write),
      .value (wr_done_count)
   );

   sat_counter #(.WIDTH(CNT_W)) u_rd_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (xfer && !cmd_q.write),
      .value (rd_done_count)
   );

   sat_counter #(.WIDTH(CNT_W)) u_to_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (timed_out),
      .value (timeout_count)
   );

endmodule

// File: tb/tb_dut_bus_master.sv
// Directed bench for dut_bus_master: a vector table of single commands with
// hand-computed latency/response, plus back-pressure, throughput and reset sequences.
module tb_dut_bus_master;

   localparam int T_CYC = 8;
   localparam int CNT_W = 16;

   logic             clk;
   logic             reset;
   logic             busy;
   logic [CNT_W-1:0] wr_done_count;
   logic [CNT_W-1:0] rd_done_count;
   logic [CNT_W-1:0] timeout_count;

   dut_bus_master_if bus ();

   dut_bus_master #(
      .TIMEOUT_CYCLES (T_CYC),
      .TMR_W          (8),
      .CNT_W          (CNT_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .bus           (bus.master),
      .busy          (busy),
      .wr_done_count (wr_done_count),
      .rd_done_count (rd_done_count),
      .timeout_count (timeout_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check_val(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Inputs are driven 2 time units after the rising edge; outputs are sampled 1 unit later.
   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   typedef struct {
      logic       write;
      logic [2:0] addr;
      logic       wdata;
      logic       rd_in;
      int         delay;     // ISSUE cycles with the matching rdy low; >= 64 means never ready
      logic       exp_rdata;
      logic       exp_err;
      int         exp_lat;   // edges from accept edge until rsp_valid is visible
   } vec_t;

   vec_t vecs[8];

   task automatic run_vec(input int idx, input vec_t v);
      int  lat;
      bit  got;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = v.write;
      bus.cmd_addr  = v.addr;
      bus.cmd_wdata = v.wdata;
      bus.rsp_ready = 1'b1;
      bus.write_rdy = !v.write;
      bus.read_rdy  = v.write;
      bus.read_data = v.rd_in;
      #1;
      check_bit($sformatf("v%0d_cmd_ready", idx), bus.cmd_ready, 1'b1);
      check_bit($sformatf("v%0d_idle_busy", idx), busy, 1'b0);
      next_cycle();
      bus.cmd_valid = 1'b0;
      bus.cmd_write = !v.write;
      bus.cmd_addr  = ~v.addr;
      bus.cmd_wdata = !v.wdata;
      lat = 0;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         if (v.write) bus.write_rdy = (k >= v.delay);
         else         bus.read_rdy  = (k >= v.delay);
         #1;
         if (v.write) begin
            check_bit($sformatf("v%0d_k%0d_write_en", idx, k), bus.write_en, logic'(k >= v.delay));
            check_bit($sformatf("v%0d_k%0d_read_en", idx, k), bus.read_en, 1'b0);
         end else begin
            check_bit($sformatf("v%0d_k%0d_read_en", idx, k), bus.read_en, logic'(k >= v.delay));
            check_bit($sformatf("v%0d_k%0d_write_en", idx, k), bus.write_en, 1'b0);
         end
         check_val($sformatf("v%0d_k%0d_waddr", idx, k), int'(bus.write_address), int'(v.addr));
         check_val($sformatf("v%0d_k%0d_raddr", idx, k), int'(bus.read_address), int'(v.addr));
         check_bit($sformatf("v%0d_k%0d_wdata", idx, k), bus.write_data, v.wdata);
         check_bit($sformatf("v%0d_k%0d_cmd_ready", idx, k), bus.cmd_ready, 1'b0);
         next_cycle();
         if (bus.rsp_valid) begin
            got = 1'b1;
            lat = k + 1;
         end
      end
      check_val($sformatf("v%0d_latency", idx), lat, v.exp_lat);
      check_bit($sformatf("v%0d_rsp_rdata", idx), bus.rsp_rdata, v.exp_rdata);
      check_bit($sformatf("v%0d_rsp_is_write", idx), bus.rsp_is_write, v.write);
      check_bit($sformatf("v%0d_rsp_error", idx), bus.rsp_error, v.exp_err);
      bus.write_rdy = 1'b1;
      bus.read_rdy  = 1'b1;
      next_cycle();
      #1;
      check_bit($sformatf("v%0d_after_rsp_valid", idx), bus.rsp_valid, 1'b0);
      check_bit($sformatf("v%0d_after_busy", idx), busy, 1'b0);
      check_bit($sformatf("v%0d_idle_write_en", idx), bus.write_en, 1'b0);
      check_bit($sformatf("v%0d_idle_read_en", idx), bus.read_en, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_wr;
      int exp_rd;
      int exp_to;
      int hs;

      //            write addr wdata rd_in delay rdata err lat
      vecs[0] = '{1'b1, 3'd4, 1'b1, 1'b0,   0, 1'b0, 1'b0, 1};
      vecs[1] = '{1'b0, 3'd3, 1'b0, 1'b1,   0, 1'b1, 1'b0, 1};
      vecs[2] = '{1'b1, 3'd6, 1'b0, 1'b0,   5, 1'b0, 1'b0, 6};
      vecs[3] = '{1'b0, 3'd3, 1'b1, 1'b1, 999, 1'b0, 1'b1, 8};
      vecs[4] = '{1'b0, 3'd5, 1'b0, 1'b0,   2, 1'b0, 1'b0, 3};
      vecs[5] = '{1'b0, 3'd7, 1'b0, 1'b1,   7, 1'b1, 1'b0, 8};
      vecs[6] = '{1'b1, 3'd1, 1'b1, 1'b0, 999, 1'b0, 1'b1, 8};
      vecs[7] = '{1'b0, 3'd0, 1'b1, 1'b1,   1, 1'b1, 1'b0, 2};

      reset         = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = 1'b0;
      bus.rsp_ready = 1'b0;
      bus.write_rdy = 1'b1;
      bus.read_rdy  = 1'b1;
      bus.read_data = 1'b0;
      next_cycle();
      #1;
      check_bit("rst_cmd_ready", bus.cmd_ready, 1'b0);
      check_bit("rst_rsp_valid", bus.rsp_valid, 1'b0);
      check_bit("rst_rsp_fields", bus.rsp_rdata | bus.rsp_is_write | bus.rsp_error, 1'b0);
      check_bit("rst_busy", busy, 1'b0);
      check_bit("rst_write_en", bus.write_en, 1'b0);
      check_bit("rst_read_en", bus.read_en, 1'b0);
      check_val("rst_waddr", int'(bus.write_address), 0);
      check_val("rst_counters", int'(wr_done_count) + int'(rd_done_count) + int'(timeout_count), 0);
      next_cycle();
      reset = 1'b0;
      #1;
      check_bit("rel_cmd_ready", bus.cmd_ready, 1'b1);

      exp_wr = 0;
      exp_rd = 0;
      exp_to = 0;
      for (int i = 0; i < 8; i++) begin
         run_vec(i, vecs[i]);
         if (vecs[i].exp_err) exp_to++;
         else if (vecs[i].write) exp_wr++;
         else exp_rd++;
      end
      check_val("tbl_wr_count", int'(wr_done_count), exp_wr);
      check_val("tbl_rd_count", int'(rd_done_count), exp_rd);
      check_val("tbl_to_count", int'(timeout_count), exp_to);

      // Back-pressure: response stalls while a new command is held on the port.
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 3'd2;
      bus.cmd_wdata = 1'b1;
      bus.rsp_ready = 1'b0;
      bus.write_rdy = 1'b1;
      bus.read_rdy  = 1'b1;
      next_cycle();
      bus.cmd_addr = 3'd5;
      next_cycle();
      for (int i = 0; i < 4; i++) begin
         #1;
         check_bit($sformatf("bp%0d_rsp_valid", i), bus.rsp_valid, 1'b1);
         check_bit($sformatf("bp%0d_cmd_ready", i), bus.cmd_ready, 1'b0);
         check_bit($sformatf("bp%0d_write_en", i), bus.write_en, 1'b0);
         check_bit($sformatf("bp%0d_read_en", i), bus.read_en, 1'b0);
         check_bit($sformatf("bp%0d_is_write", i), bus.rsp_is_write, 1'b1);
         check_bit($sformatf("bp%0d_error", i), bus.rsp_error, 1'b0);
         check_val($sformatf("bp%0d_waddr", i), int'(bus.write_address), 2);
         next_cycle();
      end
      bus.rsp_ready = 1'b1;
      #1;
      check_bit("bp_release_rsp_valid", bus.rsp_valid, 1'b1);
      next_cycle();
      #1;
      check_bit("bp_idle_busy", busy, 1'b0);
      check_bit("bp_idle_cmd_ready", bus.cmd_ready, 1'b1);
      next_cycle();
      #1;
      check_bit("bp_next_busy", busy, 1'b1);
      check_val("bp_next_waddr", int'(bus.write_address), 5);
      next_cycle();
      next_cycle();

      // Back-to-back: three commands complete within nine cycles.
      hs = 0;
      for (int c = 0; c < 9; c++) begin
         #1;
         if (bus.rsp_valid && bus.rsp_ready) hs++;
         next_cycle();
      end
      bus.cmd_valid = 1'b0;
      check_val("b2b_responses", hs, 3);
      #1;
      check_bit("b2b_end_busy", busy, 1'b0);
      check_val("b2b_wr_count", int'(wr_done_count), exp_wr + 5);

      // Reset while waiting on write_rdy.
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 3'd6;
      bus.cmd_wdata = 1'b1;
      bus.write_rdy = 1'b0;
      next_cycle();
      bus.cmd_valid = 1'b0;
      next_cycle();
      #1;
      check_bit("mr_wait_write_en", bus.write_en, 1'b0);
      check_bit("mr_wait_busy", busy, 1'b1);
      bus.write_rdy = 1'b1;
      reset         = 1'b1;
      #1;
      check_bit("mr_write_en", bus.write_en, 1'b0);
      check_bit("mr_busy", busy, 1'b0);
      check_bit("mr_rsp_valid", bus.rsp_valid, 1'b0);
      check_bit("mr_cmd_ready", bus.cmd_ready, 1'b0);
      check_val("mr_wr_count", int'(wr_done_count), 0);
      check_val("mr_waddr", int'(bus.write_address), 0);
      next_cycle();
      next_cycle();
      reset = 1'b0;
      #1;
      check_bit("mr_rel_cmd_ready", bus.cmd_ready, 1'b1);
      check_bit("mr_rel_rsp_valid", bus.rsp_valid, 1'b0);
      run_vec(8, vecs[0]);
      check_val("mr_post_wr_count", int'(wr_done_count), 1);
      check_val("mr_post_to_count", int'(timeout_count), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
